// File: rtl/display_pkg.sv
// Shared types and constants for the HEX display value controller.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

endpackage

// File: rtl/display_value_ctrl_seg7_enc.sv
// Nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}, digits 0-F.
module seg7_enc (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nib)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_value_ctrl.sv
// CPU display register sequencer: hex pass-through or double-dabble decimal
// conversion, one-deep pending write slot, registered 7-segment outputs.
//
// state | meaning
// IDLE  | waiting; accepts pending slot first, then wr_en
// SHIFT | one double-dabble iteration per clock
// LOAD  | copy BCD result into the digit register
module display_value_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NDIG  = 8,
    parameter int LZB   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_dec,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5,
    output logic [6:0]       HEX6,
    output logic [6:0]       HEX7
);

    localparam int BCD_W = 40;
    localparam int NNIB  = BCD_W / 4;
    localparam int DIG_W = 4 * NDIG;
    localparam int CW    = $clog2(WIDTH);

    disp_state_t       r_state;
    disp_state_t       w_state_nxt;

    logic [WIDTH-1:0]  r_shift;
    logic [BCD_W-1:0]  r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [DIG_W-1:0]  r_digits;
    logic              r_mode_dec;
    logic              r_ovf;
    logic              r_upd;
    logic              r_done;
    logic [WIDTH-1:0]  r_pend_data;
    logic              r_pend_dec;
    logic              r_pend_vld;
    logic [6:0]        r_hex [NDIG];

    logic              w_take_pend;
    logic              w_start;
    logic [WIDTH-1:0]  w_src_data;
    logic              w_src_dec;
    logic [BCD_W-1:0]  w_adj;
    logic [BCD_W-1:0]  w_bcd_nxt;
    logic [NDIG-1:0]   w_blank;
    logic [6:0]        w_seg [NDIG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take_pend = 1'b0;
        w_start     = 1'b0;
        w_src_data  = r_pend_vld ? r_pend_data : wr_data;
        w_src_dec   = r_pend_vld ? r_pend_dec  : wr_dec;
        case (r_state)
            IDLE: begin
                w_take_pend = r_pend_vld;
                w_start     = r_pend_vld | wr_en;
                if (w_start && w_src_dec) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 on every nibble >= 5, then shift the next binary bit in at the bottom.
    genvar g;
    generate
        for (g = 0; g < NNIB; g++) begin : g_dabble
            assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                                : r_bcd[4*g +: 4];
        end
    endgenerate

    assign w_bcd_nxt = (w_adj << 1) | BCD_W'(r_shift[WIDTH-1]);

    generate
        for (g = 0; g < NDIG; g++) begin : g_digit
            seg7_enc u_enc (
                .i_nib (r_digits[4*g +: 4]),
                .o_seg (w_seg[g])
            );
            if (g == 0) begin : g_lsd
                assign w_blank[g] = 1'b0;
            end else begin : g_upper
                assign w_blank[g] = (LZB != 0) && r_mode_dec &&
                                    ((r_digits >> (4*g)) == '0);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_digits    <= '0;
            r_mode_dec  <= 1'b1;
            r_ovf       <= 1'b0;
            r_upd       <= 1'b0;
            r_done      <= 1'b0;
            r_pend_data <= '0;
            r_pend_dec  <= 1'b0;
            r_pend_vld  <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                r_hex[i] <= (i == 0 || LZB == 0) ? SEG_ZERO : SEG_BLANK;
            end
        end else begin
            r_upd <= 1'b0;

            // A write that cannot be taken directly parks in the slot; latest wins.
            if (wr_en && (r_state != IDLE || r_pend_vld)) begin
                r_pend_data <= wr_data;
                r_pend_dec  <= wr_dec;
                r_pend_vld  <= 1'b1;
            end else if (w_take_pend) begin
                r_pend_vld  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (w_src_dec) begin
                            r_shift <= w_src_data;
                            r_bcd   <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_digits   <= DIG_W'(w_src_data);
                            r_mode_dec <= 1'b0;
                            r_ovf      <= 1'b0;
                            r_upd      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd   <= w_bcd_nxt;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                LOAD: begin
                    r_digits   <= r_bcd[DIG_W-1:0];
                    r_mode_dec <= 1'b1;
                    r_ovf      <= |r_bcd[BCD_W-1:DIG_W];
                    r_upd      <= 1'b1;
                end
                default: ;
            endcase

            r_done <= r_upd;
            for (int i = 0; i < NDIG; i++) begin
                r_hex[i] <= w_blank[i] ? SEG_BLANK : w_seg[i];
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign HEX0 = r_hex[0];
    assign HEX1 = r_hex[1];
    assign HEX2 = r_hex[2];
    assign HEX3 = r_hex[3];
    assign HEX4 = r_hex[4];
    assign HEX5 = r_hex[5];
    assign HEX6 = r_hex[6];
    assign HEX7 = r_hex[7];

endmodule

// File: tb/tb_display_value_ctrl.sv
// Self-checking bench for display_value_ctrl: vector table, random writes
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_display_value_ctrl;
    import display_pkg::*;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_dec = 1'b0;
    logic        busy, done, ovf;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [55:0] hex_all;

    int errors = 0;
    int checks = 0;

    display_value_ctrl #(.WIDTH(32), .NDIG(8), .LZB(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dec(wr_dec),
        .busy(busy), .done(done), .ovf(ovf),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
    );

    assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] data;
        logic        dec;
        logic [31:0] exp_dig;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    // Digits shown for a value: low 8 decimal digits or the raw nibbles.
    function automatic logic [31:0] ref_digits(input logic [31:0] v, input logic dec);
        longint unsigned x;
        logic [31:0] d;
        if (!dec) return v;
        x = longint'(v) % 100000000;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            d[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return d;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] v, input logic dec);
        return dec && (longint'(v) > 64'd99999999);
    endfunction

    function automatic logic [55:0] ref_hex(input logic [31:0] digs, input logic dec);
        logic [55:0] h;
        logic        blank;
        h = '0;
        for (int i = 0; i < 8; i++) begin
            blank = dec && (i > 0) && ((digs >> (4*i)) == 32'd0);
            h[7*i +: 7] = blank ? 7'h7F : seg_of(digs[4*i +: 4]);
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int bound, output int lat);
        lat = 0;
        while (!done && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", bound);
        end
    endtask

    task automatic pulse_write(input logic [31:0] d, input logic dec);
        wr_en   = 1'b1;
        wr_data = d;
        wr_dec  = dec;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [31:0] d, input logic dec,
                           input logic [31:0] exp_dig, input logic exp_ovf);
        int lat;
        int bcnt;
        @(negedge clk);
        pulse_write(d, dec);
        bcnt = busy ? 1 : 0;
        lat  = 0;
        while (!done && lat < 80) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        chk({name, "_latency"}, 64'(lat), dec ? 64'(WIDTH + 2) : 64'd1);
        chk({name, "_busy_cycles"}, 64'(bcnt), dec ? 64'(WIDTH + 1) : 64'd0);
        chk({name, "_hex"}, 64'(hex_all), 64'(ref_hex(exp_dig, dec)));
        chk({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [31:0] rd;
        logic        rdec;

        tbl[0] = '{32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{32'd12345,    1'b1, 32'h00012345, 1'b0};
        tbl[2] = '{32'hFFFFFFFF, 1'b1, 32'h94967295, 1'b1};
        tbl[3] = '{32'h00000000, 1'b0, 32'h00000000, 1'b0};
        tbl[4] = '{32'd99999999, 1'b1, 32'h99999999, 1'b0};
        tbl[5] = '{32'd100000000,1'b1, 32'h00000000, 1'b1};
        tbl[6] = '{32'd0,        1'b1, 32'h00000000, 1'b0};
        tbl[7] = '{32'h00000A05, 1'b0, 32'h00000A05, 1'b0};

        // Asynchronous reset with no clock edge yet
        #2 rst = 1'b1;
        #1;
        chk("reset_hex",  64'(hex_all), 64'(ref_hex(32'd0, 1'b1)));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ovf",  64'(ovf),  64'd0);
        chk("reset_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_one($sformatf("vec%0d", i), tbl[i].data, tbl[i].dec, tbl[i].exp_dig, tbl[i].exp_ovf);
        end

        for (int i = 0; i < 20; i++) begin
            rd   = $urandom;
            if ($urandom_range(0, 2) == 0) rd = 32'($urandom_range(0, 99999));
            rdec = 1'($urandom_range(0, 1));
            run_one($sformatf("rnd%0d", i), rd, rdec, ref_digits(rd, rdec), ref_ovf(rd, rdec));
        end

        // Two writes while busy: the later one wins and runs in the first IDLE cycle
        @(negedge clk);
        pulse_write(32'd12345, 1'b1);
        repeat (3) @(negedge clk);
        pulse_write(32'd7, 1'b1);
        repeat (2) @(negedge clk);
        pulse_write(32'd99, 1'b1);
        wait_done(60, lat);
        chk("pend_first_hex", 64'(hex_all), 64'(ref_hex(ref_digits(32'd12345, 1'b1), 1'b1)));
        @(negedge clk);
        wait_done(60, lat);
        chk("pend_second_latency", 64'(lat), 64'(WIDTH + 1));
        chk("pend_second_hex", 64'(hex_all), 64'(ref_hex(ref_digits(32'd99, 1'b1), 1'b1)));
        ndone = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("pend_no_extra_done", 64'(ndone), 64'd0);

        // New write arriving in the same cycle the pending slot drains
        @(negedge clk);
        pulse_write(32'd5, 1'b1);
        pulse_write(32'h00001234, 1'b0);
        lat = 0;
        while (busy && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("drain_idle_reached", 64'(busy), 64'd0);
        pulse_write(32'd42, 1'b1);
        chk("drain_first_done", 64'(done), 64'd1);
        chk("drain_first_hex", 64'(hex_all), 64'(ref_hex(ref_digits(32'd5, 1'b1), 1'b1)));
        @(negedge clk);
        chk("drain_hex_done", 64'(done), 64'd1);
        chk("drain_hex_hex", 64'(hex_all), 64'(ref_hex(32'h00001234, 1'b0)));
        @(negedge clk);
        wait_done(60, lat);
        chk("drain_new_latency", 64'(lat), 64'(WIDTH + 1));
        chk("drain_new_hex", 64'(hex_all), 64'(ref_hex(ref_digits(32'd42, 1'b1), 1'b1)));

        // Reset in the middle of a conversion with a write pending
        run_one("pre_reset", 32'hFFFFFFFF, 1'b1, ref_digits(32'hFFFFFFFF, 1'b1), 1'b1);
        pulse_write(32'd12345, 1'b1);
        pulse_write(32'h00000077, 1'b0);
        repeat (9) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_hex",  64'(hex_all), 64'(ref_hex(32'd0, 1'b1)));
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ovf",  64'(ovf),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        lat = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) lat++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        chk("midrst_no_busy", 64'(lat), 64'd0);
        chk("midrst_hex_after", 64'(hex_all), 64'(ref_hex(32'd0, 1'b1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
